// File: rtl/lock_chamber_ctrl_if.sv
// Signal bundle between a lock chamber controller and its operator panel.
//
// Handshake: there is no valid/ready pairing on this bus. Every switch is a
// level that the controller samples on each rising clock edge; a "press" or
// "arrival" is the first cycle a switch is seen high after being low.
// Status outputs are valid every cycle and need no acknowledge.
//
// Panel -> controller (switches):
//   outer_gondola_arrival_sw, inner_gondola_arrival_sw  arrival requests
//   outer_door_sw, inner_door_sw                        door open presses
//   inc_water_level, dec_water_level                    manual fill / drain
// Controller -> panel (status):
//   outer/inner_gondola_led, outer/inner_door_openable_led,
//   outer/inner_door_open, gondola_in_chamber, water_level, state, err
interface lock_chamber_ctrl_if #(
  parameter int LEVEL_W = 4
);
  logic               outer_gondola_arrival_sw;
  logic               inner_gondola_arrival_sw;
  logic               outer_door_sw;
  logic               inner_door_sw;
  logic               inc_water_level;
  logic               dec_water_level;
  logic               outer_gondola_led;
  logic               inner_gondola_led;
  logic               outer_door_openable_led;
  logic               inner_door_openable_led;
  logic               outer_door_open;
  logic               inner_door_open;
  logic               gondola_in_chamber;
  logic [LEVEL_W-1:0] water_level;
  logic [2:0]         state;
  logic               err;

  modport master (
    output outer_gondola_arrival_sw, inner_gondola_arrival_sw,
           outer_door_sw, inner_door_sw, inc_water_level, dec_water_level,
    input  outer_gondola_led, inner_gondola_led, outer_door_openable_led,
           inner_door_openable_led, outer_door_open, inner_door_open,
           gondola_in_chamber, water_level, state, err
  );

  modport slave (
    input  outer_gondola_arrival_sw, inner_gondola_arrival_sw,
           outer_door_sw, inner_door_sw, inc_water_level, dec_water_level,
    output outer_gondola_led, inner_gondola_led, outer_door_openable_led,
           inner_door_openable_led, outer_door_open, inner_door_open,
           gondola_in_chamber, water_level, state, err
  );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// Controller for one canal lock chamber between a low outer side (level 0)
// and a high inner side (level MAX_LEVEL). Latches arrival requests from
// both sides, arbitrates between them, and sequences entry door, water
// adjustment and exit door with a water-level interlock.
//
// Ports:
//   clk    in  rising-edge system clock
//   reset  in  asynchronous, active-low; 0 clears all state
//   bus    slave side of lock_chamber_ctrl_if (switches in, status out;
//          state doubles as the FSM debug view)
module lock_chamber_ctrl #(
  parameter int LEVEL_W       = 4,
  parameter int MAX_LEVEL     = 8,
  parameter int STEP          = 1,
  parameter int ARRIVE_CYCLES = 10,
  parameter int ENTER_CYCLES  = 4,
  parameter int DEPART_CYCLES = 10,
  parameter int AUTO_FILL     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  lock_chamber_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARRIVE     = 3'd1,
    WAIT_ENTRY = 3'd2,
    ENTER      = 3'd3,
    ADJUST     = 3'd4,
    WAIT_EXIT  = 3'd5,
    DEPART     = 3'd6
  } state_t;

  // Side encoding used for every 2-bit vector below: bit 0 outer, bit 1 inner.
  localparam logic SIDE_INNER = 1'b1;

  localparam int MAX_CYC = (ARRIVE_CYCLES > ENTER_CYCLES)
    ? ((ARRIVE_CYCLES > DEPART_CYCLES) ? ARRIVE_CYCLES : DEPART_CYCLES)
    : ((ENTER_CYCLES > DEPART_CYCLES) ? ENTER_CYCLES : DEPART_CYCLES);
  localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LVL_STEP = LEVEL_W'(STEP);
  localparam logic [LEVEL_W:0]   MAX_X    = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [LEVEL_W:0]   STEP_X   = (LEVEL_W+1)'(STEP);

  state_t             state_q, state_d;
  logic               side_q, side_d;      // side currently granted
  logic               last_q, last_d;      // side most recently served
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         flag_q, flag_d;
  logic [1:0]         arr_prev_q, door_prev_q;
  logic               err_q;

  logic [1:0]         arr_sw, door_sw, arr_rise, press, openable, grant_mask;
  logic               grant, grant_side;
  logic [LEVEL_W-1:0] entry_tgt, exit_tgt, raise_lvl, lower_lvl;
  logic [LEVEL_W:0]   up_x;
  logic               manual_ok;

  assign arr_sw   = {bus.inner_gondola_arrival_sw, bus.outer_gondola_arrival_sw};
  assign door_sw  = {bus.inner_door_sw, bus.outer_door_sw};
  assign arr_rise = arr_sw & ~arr_prev_q;
  assign press    = door_sw & ~door_prev_q;

  // A gondola enters on its own side and leaves on the opposite one.
  assign entry_tgt = (side_q == SIDE_INNER) ? LVL_MAX : '0;
  assign exit_tgt  = (side_q == SIDE_INNER) ? '0 : LVL_MAX;

  // With both requests pending, alternate away from the side served last.
  assign grant_side = (flag_q == 2'b11) ? ~last_q : flag_q[1];
  assign grant_mask = grant ? {grant_side, ~grant_side} : 2'b00;
  // A set flag ignores new edges; a grant clears its flag.
  assign flag_d     = (flag_q & ~grant_mask) | (arr_rise & ~flag_q);

  // Saturating one-step moves; with targets at 0 and MAX_LEVEL only, the
  // saturation limits are also the no-overshoot clamps for auto fill.
  assign up_x      = {1'b0, level_q} + STEP_X;
  assign raise_lvl = (up_x > MAX_X) ? LVL_MAX : up_x[LEVEL_W-1:0];
  assign lower_lvl = ({1'b0, level_q} < STEP_X) ? '0 : (level_q - LVL_STEP);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      side_q      <= 1'b0;
      last_q      <= SIDE_INNER;
      timer_q     <= '0;
      level_q     <= '0;
      flag_q      <= 2'b00;
      arr_prev_q  <= 2'b00;
      door_prev_q <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      level_q     <= level_d;
      flag_q      <= flag_d;
      arr_prev_q  <= arr_sw;
      door_prev_q <= door_sw;
      // Any press that the openable LEDs did not allow is rejected.
      err_q       <= |(press & ~openable);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    last_d  = last_q;
    timer_d = timer_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: if (|flag_q) begin
        grant   = 1'b1;
        side_d  = grant_side;
        timer_d = TMR_W'(ARRIVE_CYCLES - 1);
        state_d = ARRIVE;
      end
      ARRIVE: if (timer_q == '0) state_d = WAIT_ENTRY;
              else timer_d = timer_q - 1'b1;
      WAIT_ENTRY: if (press[side_q] && openable[side_q]) begin
        timer_d = TMR_W'(ENTER_CYCLES - 1);
        state_d = ENTER;
      end
      ENTER: if (timer_q == '0) state_d = ADJUST;
             else timer_d = timer_q - 1'b1;
      ADJUST: if (level_q == exit_tgt) state_d = WAIT_EXIT;
      WAIT_EXIT: if (press[~side_q] && openable[~side_q]) begin
        timer_d = TMR_W'(DEPART_CYCLES - 1);
        state_d = DEPART;
      end
      DEPART: if (timer_q == '0) begin
        last_d  = side_q;
        state_d = IDLE;
      end else timer_d = timer_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Water level. Doors are only open in ENTER and DEPART, where the level
  // never moves. In manual mode the level is also held on the cycle an
  // entry press is accepted and once ADJUST reaches the exit target, so the
  // door always opens at exactly the level that made it openable.
  always_comb begin
    level_d   = level_q;
    manual_ok = 1'b0;
    case (state_q)
      IDLE:       manual_ok = 1'b1;
      WAIT_ENTRY: manual_ok = (state_d == WAIT_ENTRY);
      ADJUST:     manual_ok = (level_q != exit_tgt);
      default:    manual_ok = 1'b0;
    endcase
    if (AUTO_FILL != 0) begin
      if (state_q == WAIT_ENTRY)
        level_d = (side_q == SIDE_INNER) ? raise_lvl : lower_lvl;
      else if (state_q == ADJUST)
        level_d = (side_q == SIDE_INNER) ? lower_lvl : raise_lvl;
    end else if (manual_ok) begin
      if (bus.inc_water_level && !bus.dec_water_level)      level_d = raise_lvl;
      else if (bus.dec_water_level && !bus.inc_water_level) level_d = lower_lvl;
    end
  end

  // Output logic
  always_comb begin
    openable = 2'b00;
    if (state_q == WAIT_ENTRY && level_q == entry_tgt) openable[side_q]  = 1'b1;
    if (state_q == WAIT_EXIT  && level_q == exit_tgt)  openable[~side_q] = 1'b1;

    bus.outer_gondola_led = flag_q[0] ||
      (side_q == 1'b0 && (state_q == ARRIVE || state_q == WAIT_ENTRY));
    bus.inner_gondola_led = flag_q[1] ||
      (side_q == 1'b1 && (state_q == ARRIVE || state_q == WAIT_ENTRY));
    bus.outer_door_openable_led = openable[0];
    bus.inner_door_openable_led = openable[1];
    bus.outer_door_open = (state_q == ENTER  && side_q == 1'b0) ||
                          (state_q == DEPART && side_q == 1'b1);
    bus.inner_door_open = (state_q == ENTER  && side_q == 1'b1) ||
                          (state_q == DEPART && side_q == 1'b0);
    bus.gondola_in_chamber = (state_q == ADJUST) || (state_q == WAIT_EXIT) ||
                             (state_q == DEPART);
    bus.water_level = level_q;
    bus.state       = state_q;
    bus.err         = err_q;
  end

endmodule
